// File: rtl/match_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : match_scoreboard
// Brief    : Best-of-N round/win/lose/draw scorekeeper with final verdict.
//            Optional streak tracking is enabled by defining SCORE_STREAK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module match_scoreboard #(
    parameter int CNT_W      = 4,
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             result_valid,
    input  logic [1:0]       matchresult,
    input  logic             new_game,
    output logic [CNT_W-1:0] round,
    output logic [CNT_W-1:0] win,
    output logic [CNT_W-1:0] lose,
    output logic [CNT_W-1:0] draw,
    output logic             game_over,
    output logic             over_pulse,
`ifdef SCORE_STREAK_EN
    output logic [CNT_W-1:0] cur_streak,
    output logic [CNT_W-1:0] best_streak,
`endif
    output logic [1:0]       final_result
);

    localparam logic [0:0]       S_PLAY         = 1'b0;
    localparam logic [0:0]       S_OVER         = 1'b1;
    localparam logic [1:0]       c_RES_NONE     = 2'b00;
    localparam logic [1:0]       c_RES_WIN      = 2'b01;
    localparam logic [1:0]       c_RES_DRAW     = 2'b10;
    localparam logic [1:0]       c_RES_LOSE     = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_WIN_TARGET   = CNT_W'(WIN_TARGET);
    localparam logic [CNT_W-1:0] c_MAX_ROUNDS   = CNT_W'(MAX_ROUNDS);

    generate
        if (!((WIN_TARGET >= 1) && (WIN_TARGET <= MAX_ROUNDS) &&
              (MAX_ROUNDS <= (2**CNT_W) - 1))) begin : g_bad_params
            $error("match_scoreboard: need 1 <= WIN_TARGET <= MAX_ROUNDS <= 2**CNT_W-1");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [0:0]       r_state;
    logic [0:0]       w_state_nx;
    logic [CNT_W-1:0] r_round, r_win, r_lose, r_draw;
    logic [CNT_W-1:0] w_round_nx, w_win_nx, w_lose_nx, w_draw_nx;
    logic [1:0]       r_final, w_final_nx;
    logic             r_over_pulse;
    logic             w_accept;
    logic             w_end;

    // new_game has priority: a result arriving with it is discarded.
    assign w_accept = (r_state == S_PLAY) && result_valid &&
                      (matchresult != c_RES_NONE) && !new_game;

    always_comb begin
        w_round_nx = r_round;
        w_win_nx   = r_win;
        w_lose_nx  = r_lose;
        w_draw_nx  = r_draw;
        if (w_accept) begin
            w_round_nx = sat_inc(r_round);
            case (matchresult)
                c_RES_WIN:  w_win_nx  = sat_inc(r_win);
                c_RES_LOSE: w_lose_nx = sat_inc(r_lose);
                c_RES_DRAW: w_draw_nx = sat_inc(r_draw);
                default:    ;
            endcase
        end
    end

    // Termination is judged on the post-update counts of this same edge.
    always_comb begin
        w_end      = 1'b0;
        w_final_nx = c_RES_NONE;
        if (w_accept) begin
            if (w_win_nx == c_WIN_TARGET) begin
                w_end      = 1'b1;
                w_final_nx = c_RES_WIN;
            end else if (w_lose_nx == c_WIN_TARGET) begin
                w_end      = 1'b1;
                w_final_nx = c_RES_LOSE;
            end else if (w_round_nx == c_MAX_ROUNDS) begin
                w_end = 1'b1;
                if (w_win_nx > w_lose_nx)      w_final_nx = c_RES_WIN;
                else if (w_lose_nx > w_win_nx) w_final_nx = c_RES_LOSE;
                else                           w_final_nx = c_RES_DRAW;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_PLAY;
        else         r_state <= w_state_nx;
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nx = r_state;
        if (new_game)   w_state_nx = S_PLAY;
        else if (w_end) w_state_nx = S_OVER;
    end

    // FSM: outputs
    always_comb begin
        game_over    = (r_state == S_OVER);
        over_pulse   = r_over_pulse;
        final_result = r_final;
        round        = r_round;
        win          = r_win;
        lose         = r_lose;
        draw         = r_draw;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_round      <= '0;
            r_win        <= '0;
            r_lose       <= '0;
            r_draw       <= '0;
            r_final      <= c_RES_NONE;
            r_over_pulse <= 1'b0;
        end else if (new_game) begin
            r_round      <= '0;
            r_win        <= '0;
            r_lose       <= '0;
            r_draw       <= '0;
            r_final      <= c_RES_NONE;
            r_over_pulse <= 1'b0;
        end else begin
            r_round      <= w_round_nx;
            r_win        <= w_win_nx;
            r_lose       <= w_lose_nx;
            r_draw       <= w_draw_nx;
            r_over_pulse <= w_end;
            if (w_end) r_final <= w_final_nx;
        end
    end

`ifdef SCORE_STREAK_EN
    logic [CNT_W-1:0] r_cur_streak, r_best_streak;
    logic [CNT_W-1:0] w_cur_nx, w_best_nx;

    always_comb begin
        w_cur_nx  = r_cur_streak;
        w_best_nx = r_best_streak;
        if (w_accept) begin
            if (matchresult == c_RES_WIN) w_cur_nx = sat_inc(r_cur_streak);
            else                          w_cur_nx = '0;
            if (w_cur_nx > r_best_streak) w_best_nx = w_cur_nx;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cur_streak  <= '0;
            r_best_streak <= '0;
        end else if (new_game) begin
            r_cur_streak  <= '0;
            r_best_streak <= '0;
        end else begin
            r_cur_streak  <= w_cur_nx;
            r_best_streak <= w_best_nx;
        end
    end

    assign cur_streak  = r_cur_streak;
    assign best_streak = r_best_streak;
`endif

endmodule
`default_nettype wire

// File: tb/tb_match_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_scoreboard
// Brief    : Self-checking bench for match_scoreboard (SCORE_STREAK_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_match_scoreboard;

    localparam int CNT_W      = 4;
    localparam int WIN_TARGET = 3;
    localparam int MAX_ROUNDS = 5;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             result_valid = 1'b0;
    logic [1:0]       matchresult = 2'b00;
    logic             new_game = 1'b0;
    logic [CNT_W-1:0] round, win, lose, draw;
    logic             game_over, over_pulse;
    logic [1:0]       final_result;
`ifdef SCORE_STREAK_EN
    logic [CNT_W-1:0] cur_streak, best_streak;
`endif

    match_scoreboard #(
        .CNT_W(CNT_W), .WIN_TARGET(WIN_TARGET), .MAX_ROUNDS(MAX_ROUNDS)
    ) dut (
        .clk(clk), .resetn(resetn), .result_valid(result_valid),
        .matchresult(matchresult), .new_game(new_game),
        .round(round), .win(win), .lose(lose), .draw(draw),
        .game_over(game_over), .over_pulse(over_pulse),
`ifdef SCORE_STREAK_EN
        .cur_streak(cur_streak), .best_streak(best_streak),
`endif
        .final_result(final_result)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain match-score bookkeeping.
    int m_round, m_win, m_lose, m_draw, m_final, m_cur, m_best;
    bit m_over, m_pulse;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_round = 0; m_win = 0; m_lose = 0; m_draw = 0;
        m_final = 0; m_cur = 0; m_best = 0;
        m_over = 0; m_pulse = 0;
    endtask

    function automatic int inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_step(input bit v, input int r, input bit ng);
        m_pulse = 0;
        if (ng) begin
            model_reset();
        end else if (!m_over && v && r != 0) begin
            m_round = inc(m_round);
            if (r == 1) begin m_win = inc(m_win); m_cur = inc(m_cur); end
            else begin
                if (r == 3) m_lose = inc(m_lose); else m_draw = inc(m_draw);
                m_cur = 0;
            end
            if (m_cur > m_best) m_best = m_cur;
            if (m_win == WIN_TARGET)       begin m_over = 1; m_final = 1; end
            else if (m_lose == WIN_TARGET) begin m_over = 1; m_final = 3; end
            else if (m_round == MAX_ROUNDS) begin
                m_over  = 1;
                m_final = (m_win > m_lose) ? 1 : (m_lose > m_win) ? 3 : 2;
            end
            m_pulse = m_over;
        end
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (!resetn) model_reset();
        else         model_step(result_valid, int'(matchresult), new_game);
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        chk("round", int'(round), m_round);
        chk("win", int'(win), m_win);
        chk("lose", int'(lose), m_lose);
        chk("draw", int'(draw), m_draw);
        chk("game_over", int'(game_over), int'(m_over));
        chk("over_pulse", int'(over_pulse), int'(m_pulse));
        chk("final_result", int'(final_result), m_final);
`ifdef SCORE_STREAK_EN
        chk("cur_streak", int'(cur_streak), m_cur);
        chk("best_streak", int'(best_streak), m_best);
`endif
    end

    // Drive one edge's worth of input, return 1ns after that edge.
    task automatic step(input bit v, input logic [1:0] r, input bit ng);
        @(negedge clk); #1;
        result_valid = v; matchresult = r; new_game = ng;
        @(posedge clk); #1;
        result_valid = 1'b0; new_game = 1'b0;
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        chk({"lit_", nm}, act, exp);
    endtask

    task automatic restart();
        step(1'b0, 2'b00, 1'b1);
    endtask

    initial begin
        #3;
        lit("reset_round", int'(round), 0);
        lit("reset_over", int'(game_over), 0);
        lit("reset_final", int'(final_result), 0);
        #9 resetn = 1'b1;

        // Three P1 wins end the match early
        step(1, 2'b01, 0); step(1, 2'b01, 0);
        lit("pre_pulse", int'(over_pulse), 0);
        step(1, 2'b01, 0);
        lit("s1_win", int'(win), 3);
        lit("s1_round", int'(round), 3);
        lit("s1_lose", int'(lose), 0);
        lit("s1_pulse", int'(over_pulse), 1);
        lit("s1_over", int'(game_over), 1);
        lit("s1_final", int'(final_result), 1);
        step(0, 2'b00, 0);
        lit("s1_pulse_once", int'(over_pulse), 0);

        // Round limit reached on a tie -> draw verdict
        restart();
        step(1, 2'b01, 0); step(1, 2'b11, 0); step(1, 2'b10, 0);
        step(1, 2'b11, 0); step(1, 2'b01, 0);
        lit("s2_round", int'(round), 5);
        lit("s2_win", int'(win), 2);
        lit("s2_lose", int'(lose), 2);
        lit("s2_draw", int'(draw), 1);
        lit("s2_final", int'(final_result), 2);
        lit("s2_over", int'(game_over), 1);

        // Results ignored in OVER
        for (int i = 0; i < 4; i++) step(1, 2'b11, 0);
        lit("s3_lose_held", int'(lose), 2);
        lit("s3_pulse", int'(over_pulse), 0);
        restart();
        lit("s3_round", int'(round), 0);
        lit("s3_over", int'(game_over), 0);
        lit("s3_final", int'(final_result), 0);

        // No-result code, invalid strobe, new_game priority
        for (int i = 0; i < 3; i++) step(1, 2'b00, 0);
        step(0, 2'b01, 0);
        lit("s4_round", int'(round), 0);
        lit("s4_win", int'(win), 0);
        step(1, 2'b01, 1);
        lit("s4_ng_win", int'(win), 0);

        // Asynchronous reset mid-match
        step(1, 2'b01, 0); step(1, 2'b01, 0);
        lit("s5_pre", int'(win), 2);
        #1 resetn = 1'b0;
        model_reset();
        #1;
        lit("s5_win0", int'(win), 0);
        lit("s5_round0", int'(round), 0);
        lit("s5_pulse", int'(over_pulse), 0);
        resetn = 1'b1;
        step(1, 2'b01, 0);
        lit("s5_win1", int'(win), 1);

`ifdef SCORE_STREAK_EN
        restart();
        step(1, 2'b01, 0); step(1, 2'b01, 0); step(1, 2'b10, 0); step(1, 2'b01, 0);
        lit("streak_cur", int'(cur_streak), 1);
        lit("streak_best", int'(best_streak), 2);
`endif

        // Randomised play with occasional restarts and resets
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                @(negedge clk); #2 resetn = 1'b0;
                model_reset();
                #1 resetn = 1'b1;
            end else if (sel < 8) begin
                step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1);
            end else if (sel < 75) begin
                step(1, 2'($urandom_range(0, 3)), 0);
            end else begin
                step(0, 2'($urandom_range(0, 3)), 0);
            end
        end

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/match_scoreboard.md
Name: match_scoreboard

Overview:
- Parametrised round/win/lose/draw scorekeeper for the two-player game datapath; consumes one judged round result per valid strobe from the round judge.
- Adds draw counting, best-of-N match termination, a final verdict and a new-game restart, all synchronous to a single clock. Feeds the score display and the top-level game FSM.

Parameters:
- CNT_W, 4, width of every score counter; counters saturate at 2^CNT_W-1.
- WIN_TARGET, 3, wins needed by either player to end the match.
- MAX_ROUNDS, 5, round limit; match ends when round count reaches it. Legal only if 1 <= WIN_TARGET <= MAX_ROUNDS <= 2^CNT_W-1; elaboration error otherwise.

Ports:
- clk  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous active-low reset.
- result_valid  in  1  one-cycle strobe: matchresult is valid this cycle.
- matchresult  in  2  2'b01 = P1 win, 2'b11 = P1 lose (P2 win), 2'b10 = draw, 2'b00 = no result.
- new_game  in  1  synchronous pulse: clear scores, restart match.
- round  out  CNT_W  rounds counted in current match.
- win  out  CNT_W  P1 wins.
- lose  out  CNT_W  P1 losses.
- draw  out  CNT_W  draws.
- game_over  out  1  high while in OVER state.
- over_pulse  out  1  one-cycle pulse on the PLAY->OVER edge.
- final_result  out  2  match verdict, same encoding as matchresult; 2'b00 while PLAY.

Behaviour:
- Reset (resetn low, asynchronous): all counters 0, state PLAY, game_over 0, over_pulse 0, final_result 2'b00. Release takes effect on next clk edge.
- States: PLAY, OVER. All outputs registered; an accepted result is visible the cycle after the edge sampling it (latency 1).
- PLAY, result_valid=1 and matchresult != 2'b00: round +1; win/lose/draw +1 per encoding. matchresult 2'b00 with valid: ignored, no count changes.
- result_valid=0: no change.
- Termination, evaluated on post-update values in the same edge: win==WIN_TARGET -> OVER, final 2'b01; lose==WIN_TARGET -> OVER, final 2'b11; else round==MAX_ROUNDS -> OVER, final = 2'b01 if win>lose, 2'b11 if lose>win, 2'b10 if equal. Counts and game_over/final_result update on the same edge; over_pulse high exactly that following cycle.
- OVER: result_valid ignored, counters and final_result held, game_over held 1.
- new_game (either state): next edge clears all counters, final_result 2'b00, game_over 0, state PLAY. new_game and result_valid in same cycle: new_game wins, result discarded.
- Saturation: no counter wraps; any increment at 2^CNT_W-1 holds the value (unreachable for legal parameters, kept as guard).
- resetn asserted mid-match: immediate return to reset values; no pulse generated.

Optional Feature:
- SCORE_STREAK_EN: when defined, adds outputs cur_streak [CNT_W] and best_streak [CNT_W]. cur_streak +1 on each P1 win, cleared to 0 on lose or draw; best_streak = max seen this match. Both cleared by reset and new_game, held in OVER, saturating. When undefined, ports and logic are absent; all other behaviour identical.

Test Plan:
- Reset then 3 valid results 2'b01 -> win=3, round=3, lose=0; over_pulse one cycle; game_over=1, final_result=2'b01.
- Sequence 01,11,10,11,01 (MAX_ROUNDS=5) -> round=5, win=2, lose=2, draw=1, final_result=2'b10, game_over=1.
- In OVER, apply 4 valid 2'b11 -> all counts unchanged, over_pulse stays 0; then new_game -> all counts 0, game_over=0, final_result=2'b00.
- Valid 2'b00 ×3 and result_valid=0 with 2'b01 on bus -> round=0, win=0; new_game with valid 2'b01 same cycle -> win=0.
- Mid-match (win=2) pulse resetn low between edges -> outputs 0 immediately, no over_pulse; next 2'b01 gives win=1.
- SCORE_STREAK_EN defined: 01,01,10,01 -> cur_streak=1, best_streak=2.
